// File: rtl/butterfly_seq_core_if.sv
// Operand/result bundle for butterfly_seq_core.
//   din     operand word (signed, W bits)
//   load    asynchronous load strobe, synchronised inside the core
//   w_load  1 = 6-word frame (twiddle + operands), 0 = 4-word frame reusing stored twiddle
//   inv     use the conjugate twiddle
//   scale   halve each result before saturation
//   dout    result word while valid, else 0
//   idx     word index expected (LOAD) or shown (SHOW)
//   busy    multiply/add in progress
//   valid   results being presented
//   ovf     a result of the current frame saturated
interface butterfly_seq_core_if #(
   parameter int unsigned W = 8
);
   logic [W-1:0] din;
   logic         load;
   logic         w_load;
   logic         inv;
   logic         scale;
   logic [W-1:0] dout;
   logic [2:0]   idx;
   logic         busy;
   logic         valid;
   logic         ovf;

   modport master (
      output din, load, w_load, inv, scale,
      input  dout, idx, busy, valid, ovf
   );

   modport slave (
      input  din, load, w_load, inv, scale,
      output dout, idx, busy, valid, ovf
   );
endinterface

// File: rtl/butterfly_seq_core.sv
// Sequential radix-2 butterfly: y = a + b*w, z = a - b*w in signed fixed point.
// Operands arrive one word per rising edge of a slow load strobe; the four results
// (Re y, Im y, Re z, Im z) are then stepped out one per strobe edge.
//   clk    rising-edge clock
//   reset  synchronous, active-high
//   bus    butterfly_seq_core_if.slave (operand/strobe inputs, result/status outputs)
module butterfly_seq_core #(
   parameter int unsigned W    = 8,
   parameter int unsigned FRAC = 7
) (
   input  logic                 clk,
   input  logic                 reset,
   butterfly_seq_core_if.slave  bus
);

   localparam int unsigned W1 = W + 1;
   localparam int unsigned W2 = 2 * W;
   // Wide enough that neither the twiddle sum nor the a +/- t sum can wrap.
   localparam int unsigned SW = 2 * W + 3;
   localparam logic signed [SW-1:0] Half = SW'(1 << (FRAC - 1));
   localparam logic signed [SW-1:0] MaxV = SW'((1 << (W - 1)) - 1);
   localparam logic signed [SW-1:0] MinV = ~MaxV;

   typedef enum logic [1:0] {StLoad, StMul, StAdd, StShow} state_e;

   state_e state_q, state_d;
   logic   s1_q, s2_q, s3_q, rise;
   logic   [2:0] idx_q, idx_d;
   logic   long_q, long_d, frame_long;
   logic   [2:0] slot;
   // Operand slots: 0 Re w, 1 Im w, 2 Re b, 3 Im b, 4 Re a, 5 Im a.
   logic   signed [W-1:0] opr_q [6];
   logic   signed [W-1:0] opr_d [6];
   logic   signed [W2-1:0] prr_q, pii_q, pri_q, pir_q;
   logic   signed [W2-1:0] prr_d, pii_d, pri_d, pir_d;
   logic   signed [W-1:0] res_q [4];
   logic   signed [W-1:0] res_d [4];
   logic   ovf_q, ovf_d, busy_q, busy_d, valid_q, valid_d;
   logic   signed [W-1:0] dout_q, dout_d;

   logic   signed [W1-1:0] wim_eff;
   logic   signed [W2-1:0] m_rr, m_ii, m_ri, m_ir;
   logic   signed [SW-1:0] tr, ti, tr_r, ti_r;
   logic   signed [SW-1:0] sum [4];
   logic   signed [W-1:0] sat_res [4];
   logic   [3:0] sat_hit;

   assign rise = s2_q & ~s3_q;

   // Products; W+1 bits for Im w so that negating the most negative twiddle is exact.
   always_comb begin
      wim_eff = W1'(opr_q[1]);
      if (bus.inv) begin
         wim_eff = -wim_eff;
      end
      m_rr = W2'(opr_q[2]) * W2'(opr_q[0]);
      m_ii = W2'(opr_q[3]) * W2'(wim_eff);
      m_ri = W2'(opr_q[2]) * W2'(wim_eff);
      m_ir = W2'(opr_q[3]) * W2'(opr_q[0]);
   end

   // Twiddle sums, round half-up, butterfly, optional halving, saturation.
   always_comb begin
      tr     = SW'(prr_q) - SW'(pii_q);
      ti     = SW'(pri_q) + SW'(pir_q);
      tr_r   = (tr + Half) >>> FRAC;
      ti_r   = (ti + Half) >>> FRAC;
      sum[0] = SW'(opr_q[4]) + tr_r;
      sum[1] = SW'(opr_q[5]) + ti_r;
      sum[2] = SW'(opr_q[4]) - tr_r;
      sum[3] = SW'(opr_q[5]) - ti_r;
      sat_hit = '0;
      for (int i = 0; i < 4; i++) begin
         logic signed [SW-1:0] v;
         v = bus.scale ? (sum[i] >>> 1) : sum[i];
         sat_res[i] = v[W-1:0];
         if (v > MaxV) begin
            sat_res[i] = MaxV[W-1:0];
            sat_hit[i] = 1'b1;
         end else if (v < MinV) begin
            sat_res[i] = MinV[W-1:0];
            sat_hit[i] = 1'b1;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      long_d  = long_q;
      opr_d   = opr_q;
      prr_d   = prr_q;
      pii_d   = pii_q;
      pri_d   = pri_q;
      pir_d   = pir_q;
      res_d   = res_q;
      ovf_d   = ovf_q;
      // Frame length is decided by w_load at the first word, then held.
      frame_long = (idx_q == 3'd0) ? bus.w_load : long_q;
      slot       = frame_long ? idx_q : idx_q + 3'd2;
      unique case (state_q)
         StLoad: begin
            if (rise) begin
               long_d      = frame_long;
               opr_d[slot] = bus.din;
               if (idx_q == (frame_long ? 3'd5 : 3'd3)) begin
                  state_d = StMul;
                  idx_d   = 3'd0;
               end else begin
                  idx_d = idx_q + 3'd1;
               end
            end
         end
         StMul: begin
            prr_d   = m_rr;
            pii_d   = m_ii;
            pri_d   = m_ri;
            pir_d   = m_ir;
            state_d = StAdd;
         end
         StAdd: begin
            res_d   = sat_res;
            ovf_d   = |sat_hit;
            state_d = StShow;
            idx_d   = 3'd0;
         end
         StShow: begin
            if (rise) begin
               if (idx_q == 3'd3) begin
                  state_d = StLoad;
                  idx_d   = 3'd0;
                  ovf_d   = 1'b0;
               end else begin
                  idx_d = idx_q + 3'd1;
               end
            end
         end
         default: state_d = StLoad;
      endcase
      // Outputs are registered from next-state values so they line up with the state.
      busy_d  = (state_d == StMul) || (state_d == StAdd);
      valid_d = (state_d == StShow);
      dout_d  = valid_d ? res_d[idx_d[1:0]] : '0;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StLoad;
         s1_q    <= 1'b0;
         s2_q    <= 1'b0;
         s3_q    <= 1'b0;
         idx_q   <= '0;
         long_q  <= 1'b0;
         opr_q   <= '{default: '0};
         prr_q   <= '0;
         pii_q   <= '0;
         pri_q   <= '0;
         pir_q   <= '0;
         res_q   <= '{default: '0};
         ovf_q   <= 1'b0;
         busy_q  <= 1'b0;
         valid_q <= 1'b0;
         dout_q  <= '0;
      end else begin
         state_q <= state_d;
         s1_q    <= bus.load;
         s2_q    <= s1_q;
         s3_q    <= s2_q;
         idx_q   <= idx_d;
         long_q  <= long_d;
         opr_q   <= opr_d;
         prr_q   <= prr_d;
         pii_q   <= pii_d;
         pri_q   <= pri_d;
         pir_q   <= pir_d;
         res_q   <= res_d;
         ovf_q   <= ovf_d;
         busy_q  <= busy_d;
         valid_q <= valid_d;
         dout_q  <= dout_d;
      end
   end

   assign bus.dout  = dout_q;
   assign bus.idx   = idx_q;
   assign bus.busy  = busy_q;
   assign bus.valid = valid_q;
   assign bus.ovf   = ovf_q;

endmodule
